// File: rtl/esc_ping_responder_pkg.sv
// Shared definitions for the escalation/ping responder.
// Contents:
//   resp_state_e   - responder FSM state (2-bit encoded)
//   CNT_DW_DEFAULT - default watchdog counter width, same as the ping timer counter
package esc_ping_responder_pkg;

    localparam int unsigned CNT_DW_DEFAULT = 24;

    // Every encoding is in use. Decoding is still written so that anything
    // which is not Idle/Check/EscResp behaves as SigInt.
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCheck   = 2'b01,
        StEscResp = 2'b10,
        StSigInt  = 2'b11
    } resp_state_e;

endpackage

// File: rtl/esc_ping_wdog.sv
// Ping watchdog: saturating up-counter with a clear input, a compare against a
// programmable limit, and a sticky expiry flag.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the window (a ping/escalation was accepted)
//   limit     - window length in cycles; 0 disables the watchdog
//   expired   - sticky, set once the window ran out; cleared only by reset
module esc_ping_wdog #(
    parameter int unsigned CntDw = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CntDw-1:0] limit,
    output logic             expired
);

    logic [CntDw-1:0] cnt;
    logic             enabled;
    logic             hit;

    assign enabled = (limit != '0);
    // A clear in the same cycle as the limit being reached wins over the expiry.
    assign hit     = enabled && !clear && (cnt >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            if (clear || !enabled) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CntDw'(1);
            end
            if (hit) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/esc_ping_responder.sv
// Receiver-side responder for the differential escalation/ping link.
// Decodes esc_p_i/esc_n_i into ping, escalation or signal-integrity error,
// drives the differential response pair back to the sender, raises a local
// escalation request, and self-escalates when no ping arrives in time.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   esc_p_i/esc_n_i - differential request pair (synchronous to clk_i)
//   timeout_cyc_i  - watchdog window in cycles, 0 disables it
//   resp_p_o/resp_n_o - registered differential response pair
//   esc_req_o      - local escalation request (FSM escalation or watchdog)
//   ping_seen_o    - 1-cycle pulse when a ping completes
//   sigint_o       - input pair invalid
//   timeout_o      - sticky watchdog expiry
module esc_ping_responder
    import esc_ping_responder_pkg::*;
#(
    parameter int unsigned CntDw = CNT_DW_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             esc_p_i,
    input  logic             esc_n_i,
    input  logic [CntDw-1:0] timeout_cyc_i,
    output logic             resp_p_o,
    output logic             resp_n_o,
    output logic             esc_req_o,
    output logic             ping_seen_o,
    output logic             sigint_o,
    output logic             timeout_o
);

    logic        active;
    logic        idle;
    logic        sigint_in;
    logic        ping_start;
    logic        timeout;
    resp_state_e state;
    logic        resp_p;
    logic        resp_n;
    logic        fsm_esc;
    logic        ping_seen;
    logic        sigint;

    assign active    = esc_p_i & ~esc_n_i;
    assign idle      = ~esc_p_i & esc_n_i;
    assign sigint_in = (esc_p_i == esc_n_i);

    // Entry into Check restarts the watchdog window (active excludes sigint_in).
    assign ping_start = (state == StIdle) && active;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= StIdle;
            resp_p    <= 1'b0;
            resp_n    <= 1'b1;
            fsm_esc   <= 1'b0;
            ping_seen <= 1'b0;
            sigint    <= 1'b0;
        end else begin
            ping_seen <= 1'b0;
            if (sigint_in) begin
                // Equal rails toggling together so the sender flags the error.
                state   <= StSigInt;
                sigint  <= 1'b1;
                fsm_esc <= 1'b1;
                if (state == StSigInt) begin
                    resp_p <= ~resp_p;
                    resp_n <= ~resp_p;
                end else begin
                    resp_p <= 1'b1;
                    resp_n <= 1'b1;
                end
            end else begin
                case (state)
                    StIdle: begin
                        if (active) begin
                            state  <= StCheck;
                            resp_p <= 1'b1;
                            resp_n <= 1'b0;
                        end
                    end
                    StCheck: begin
                        if (idle) begin
                            state     <= StIdle;
                            resp_p    <= 1'b0;
                            resp_n    <= 1'b1;
                            ping_seen <= 1'b1;
                        end else if (active) begin
                            state   <= StEscResp;
                            resp_p  <= 1'b0;
                            resp_n  <= 1'b1;
                            fsm_esc <= 1'b1;
                        end
                    end
                    StEscResp: begin
                        if (active) begin
                            resp_p  <= ~resp_p;
                            resp_n  <= resp_p;
                            fsm_esc <= 1'b1;
                        end else begin
                            state   <= StIdle;
                            resp_p  <= 1'b0;
                            resp_n  <= 1'b1;
                            fsm_esc <= 1'b0;
                        end
                    end
                    default: begin
                        // SigInt with a now-valid pair: back to Idle.
                        state   <= StIdle;
                        sigint  <= 1'b0;
                        fsm_esc <= 1'b0;
                        resp_p  <= 1'b0;
                        resp_n  <= 1'b1;
                    end
                endcase
            end
        end
    end

    esc_ping_wdog #(
        .CntDw(CntDw)
    ) u_wdog (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (ping_start),
        .limit   (timeout_cyc_i),
        .expired (timeout)
    );

    assign resp_p_o    = resp_p;
    assign resp_n_o    = resp_n;
    assign esc_req_o   = fsm_esc | timeout;
    assign ping_seen_o = ping_seen;
    assign sigint_o    = sigint;
    assign timeout_o   = timeout;

endmodule

// File: tb/tb_esc_ping_responder.sv
// Directed bench for esc_ping_responder: ping, escalation, signal-integrity
// error, asynchronous reset, and watchdog expiry/suppression cases.
module tb_esc_ping_responder;

    localparam int unsigned CntDw = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             esc_p;
    logic             esc_n;
    logic [CntDw-1:0] timeout_cyc;
    logic             resp_p;
    logic             resp_n;
    logic             esc_req;
    logic             ping_seen;
    logic             sigint;
    logic             timeout;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    esc_ping_responder #(
        .CntDw(CntDw)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .esc_p_i       (esc_p),
        .esc_n_i       (esc_n),
        .timeout_cyc_i (timeout_cyc),
        .resp_p_o      (resp_p),
        .resp_n_o      (resp_n),
        .esc_req_o     (esc_req),
        .ping_seen_o   (ping_seen),
        .sigint_o      (sigint),
        .timeout_o     (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; outputs then show that edge's result.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic p, input logic n);
        esc_p = p;
        esc_n = n;
    endtask

    task automatic chk_all(input string tag, input logic rp, input logic rn, input logic er,
                           input logic ps, input logic si, input logic to);
        chk({tag, ".resp_p"},    resp_p,    rp);
        chk({tag, ".resp_n"},    resp_n,    rn);
        chk({tag, ".esc_req"},   esc_req,   er);
        chk({tag, ".ping_seen"}, ping_seen, ps);
        chk({tag, ".sigint"},    sigint,    si);
        chk({tag, ".timeout"},   timeout,   to);
    endtask

    // Reset pulse that both asserts and releases away from the clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #4 rst = 1'b0;
    endtask

    // One ping, then idle for the rest of a 'period'-cycle slot.
    task automatic ping_slot(input int unsigned period);
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        steps(period - 1);
    endtask

    initial begin
        rst         = 1'b1;
        timeout_cyc = '0;
        drive(1'b0, 1'b1);
        #3;
        chk_all("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #10 rst = 1'b0;
        steps(3);
        chk_all("idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ping: one-cycle resp_p, ping_seen the cycle after.
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        chk_all("ping_c11", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("ping_c12", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("ping_c13", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps(5);

        // Escalation: active for 6 cycles.
        drive(1'b1, 1'b0);
        step();
        chk_all("esc_c11", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("esc_c12", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("esc_c13", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("esc_c14", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("esc_c15", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1);
        chk_all("esc_c16", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("esc_c17", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps(2);

        // Sigint from Idle: pair high for 3 cycles.
        drive(1'b1, 1'b1);
        step();
        chk_all("sig_c21", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("sig_c22", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        chk_all("sig_c23", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("sig_c24", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps(2);

        // Sigint with both rails low for a single cycle.
        drive(1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1);
        chk_all("sig00_a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("sig00_b", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps(2);

        // Sigint interrupting an escalation in progress.
        drive(1'b1, 1'b0);
        steps(2);
        chk_all("escsig_esc", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1);
        step();
        drive(1'b0, 1'b1);
        chk_all("escsig_sig", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("escsig_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps(2);

        // Asynchronous reset in EscResp while resp_p is high.
        drive(1'b1, 1'b0);
        steps(3);
        chk_all("rstesc_pre", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("rstesc_async", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1);
        #3 rst = 1'b0;
        steps(2);
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        chk_all("rstesc_ping1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("rstesc_ping2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        steps(2);

        // Watchdog satisfied: pings every 50 cycles for 2000 cycles.
        timeout_cyc = 24'd100;
        for (int i = 0; i < 40; i++) ping_slot(50);
        chk("wdog_p50.timeout", timeout, 1'b0);
        chk("wdog_p50.esc_req", esc_req, 1'b0);

        // Period exactly equal to the window still never expires.
        for (int i = 0; i < 5; i++) ping_slot(100);
        chk("wdog_p100.timeout", timeout, 1'b0);

        // Watchdog disabled, no pings.
        timeout_cyc = '0;
        steps(300);
        chk("wdog_off.timeout", timeout, 1'b0);
        chk("wdog_off.esc_req", esc_req, 1'b0);

        // Watchdog expiry: sets on the 101st edge after reset release.
        timeout_cyc = 24'd100;
        do_reset();
        steps(100);
        chk("wdog_exp_c100.timeout", timeout, 1'b0);
        chk("wdog_exp_c100.esc_req", esc_req, 1'b0);
        step();
        chk("wdog_exp_c101.timeout", timeout, 1'b1);
        chk("wdog_exp_c101.esc_req", esc_req, 1'b1);
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        chk_all("wdog_exp_ping1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("wdog_exp_ping2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        steps(200);
        chk("wdog_exp_sticky", timeout, 1'b1);

        // Ping arriving in the cycle the window is reached suppresses expiry.
        do_reset();
        chk("wdog_rst.timeout", timeout, 1'b0);
        steps(100);
        drive(1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1);
        chk("wdog_race.timeout", timeout, 1'b0);
        chk("wdog_race.resp_p", resp_p, 1'b1);
        steps(50);
        chk("wdog_race_later.timeout", timeout, 1'b0);
        chk("wdog_race_later.esc_req", esc_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
